// File: rtl/tdm_demux4.sv
// ----------------------------------------------------------------------------
// tdm_demux4
// Receive side of a 4-way time-division multiplexed data path. Samples arrive
// in rotating slot order 0,1,2,3. A frame-sync mark identifies slot 0. Slots
// 0..2 are held in shadow registers. When slot 3 arrives, all four output
// channels are loaded on the same edge. The block tracks frame alignment,
// pulses sync_err on a protocol violation and re-aligns on the next sync.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : slot sample, W bits
//   din_vld    : din holds a valid sample this cycle
//   frm_sync   : valid sample is slot 0 (ignored when din_vld=0)
//   a,b,c,d    : channel 0..3 outputs, registered, updated per completed frame
//   frame_done : one-cycle pulse, a..d were just loaded with a new frame
//   locked     : 1 while aligned to the frame
//   sync_err   : one-cycle pulse on a protocol violation
//   slot       : next expected slot index
// ----------------------------------------------------------------------------
module tdm_demux4 #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic         din_vld,
   input  logic         frm_sync,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic [W-1:0] d,
   output logic         frame_done,
   output logic         locked,
   output logic         sync_err,
   output logic [1:0]   slot
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t       state;
   logic [W-1:0] s0;
   logic [W-1:0] s1;
   logic [W-1:0] s2;

   // Frame alignment FSM, shadow capture and output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         s0         <= '0;
         s1         <= '0;
         s2         <= '0;
         a          <= '0;
         b          <= '0;
         c          <= '0;
         d          <= '0;
         slot       <= 2'd0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         // Pulses default low; asserted below for one cycle only
         frame_done <= 1'b0;
         sync_err   <= 1'b0;

         case (state)
            HUNT: begin
               // Everything except a synced sample is discarded silently
               if (din_vld && frm_sync) begin
                  s0     <= din;
                  slot   <= 2'd1;
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end

            LOCKED: begin
               if (din_vld) begin
                  if (frm_sync) begin
                     // A sync restarts the frame. If it lands on slot 1..3
                     // the partial frame is dropped and a..d stay untouched.
                     if (slot != 2'd0) begin
                        sync_err <= 1'b1;
                     end
                     s0   <= din;
                     slot <= 2'd1;
                  end else begin
                     case (slot)
                        2'd0: begin
                           // Slot 0 without sync: alignment lost
                           sync_err <= 1'b1;
                           slot     <= 2'd0;
                           state    <= HUNT;
                           locked   <= 1'b0;
                        end
                        2'd1: begin
                           s1   <= din;
                           slot <= 2'd2;
                        end
                        2'd2: begin
                           s2   <= din;
                           slot <= 2'd3;
                        end
                        2'd3: begin
                           // Slot 3 goes straight to d so the frame lands
                           // on all four channels on the same edge
                           a          <= s0;
                           b          <= s1;
                           c          <= s2;
                           d          <= din;
                           frame_done <= 1'b1;
                           slot       <= 2'(slot + 2'd1);
                        end
                        default: begin
                           slot <= 2'd0;
                        end
                     endcase
                  end
               end
            end

            default: begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux4
// Self-checking bench for tdm_demux4 (W=4). Expected frames are pushed to a
// scoreboard queue when their completing sample is driven; a negedge monitor
// pops and compares them whenever frame_done is seen.
// ----------------------------------------------------------------------------
module tb_tdm_demux4;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         din_vld;
   logic         frm_sync;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c;
   logic [W-1:0] d;
   logic         frame_done;
   logic         locked;
   logic         sync_err;
   logic [1:0]   slot;

   int checks;
   int failures;
   int done_cnt;
   int err_cnt;
   logic [4*W-1:0] sb[$];

   tdm_demux4 #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_vld    (din_vld),
      .frm_sync   (frm_sync),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err),
      .slot       (slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame scoreboard and pulse counters
   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
         end else begin
            logic [4*W-1:0] e;
            e = sb.pop_front();
            check("frame_abcd", 32'({a, b, c, d}), 32'(e));
         end
      end
      if (sync_err === 1'b1) err_cnt++;
      if (frame_done === 1'b1 || sync_err === 1'b1)
         check("pulse_excl", 32'(frame_done & sync_err), 32'd0);
   end

   task automatic send(input logic [W-1:0] v, input logic s);
      din      = v;
      din_vld  = 1'b1;
      frm_sync = s;
      @(posedge clk);
      #1;
      din_vld  = 1'b0;
      frm_sync = 1'b0;
      din      = '0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Asynchronous reset pulse placed mid-cycle, outputs checked immediately
   task automatic reset_mid(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_abcd"}, 32'({a, b, c, d}), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_slot"}, 32'(slot), 32'd0);
      #3;
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned d0;
      int unsigned e0;
      logic [W-1:0] f1 [4];
      logic [W-1:0] f2 [4];

      checks   = 0;
      failures = 0;
      done_cnt = 0;
      err_cnt  = 0;
      din      = '0;
      din_vld  = 1'b0;
      frm_sync = 1'b0;
      rst_n    = 1'b1;

      // 1. Reset then idle
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_abcd", 32'({a, b, c, d}), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_err", 32'(sync_err), 32'd0);
      #9;
      rst_n = 1'b1;
      idle(10);
      check("idle_abcd", 32'({a, b, c, d}), 32'd0);
      check("idle_locked", 32'(locked), 32'd0);
      check("idle_slot", 32'(slot), 32'd0);
      check("idle_pulses", 32'(done_cnt + err_cnt), 32'd0);

      // 2. Clean frame
      sb.push_back({4'h3, 4'h7, 4'hA, 4'hC});
      send(4'h3, 1'b1);
      check("t2_locked", 32'(locked), 32'd1);
      check("t2_slot1", 32'(slot), 32'd1);
      send(4'h7, 1'b0);
      send(4'hA, 1'b0);
      check("t2_slot3", 32'(slot), 32'd3);
      check("t2_hold", 32'({a, b, c, d}), 32'd0);
      send(4'hC, 1'b0);
      check("t2_abcd", 32'({a, b, c, d}), 32'h37AC);
      check("t2_done", 32'(frame_done), 32'd1);
      check("t2_wrap", 32'(slot), 32'd0);
      idle(1);
      check("t2_done_1cyc", 32'(frame_done), 32'd0);
      check("t2_abcd_hold", 32'({a, b, c, d}), 32'h37AC);

      // 3. Back-to-back frames with random gaps
      f1 = '{4'h1, 4'h2, 4'h3, 4'h4};
      f2 = '{4'h5, 4'h6, 4'h7, 4'h8};
      d0 = done_cnt;
      sb.push_back({f1[0], f1[1], f1[2], f1[3]});
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         send(f1[i], i == 0);
      end
      sb.push_back({f2[0], f2[1], f2[2], f2[3]});
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         if (i == 3) check("t3_hold_f1", 32'({a, b, c, d}), 32'h1234);
         send(f2[i], i == 0);
      end
      check("t3_abcd", 32'({a, b, c, d}), 32'h5678);
      idle(1);
      check("t3_done_cnt", 32'(done_cnt - d0), 32'd2);

      // 4. Hunt filtering after a fresh reset
      reset_mid("t4_rst");
      e0 = err_cnt;
      send(4'h5, 1'b0);
      send(4'h6, 1'b0);
      send(4'h7, 1'b0);
      check("t4_hunt_locked", 32'(locked), 32'd0);
      check("t4_hunt_abcd", 32'({a, b, c, d}), 32'd0);
      sb.push_back({4'h9, 4'h9, 4'h9, 4'h9});
      send(4'h9, 1'b1);
      send(4'h9, 1'b0);
      send(4'h9, 1'b0);
      send(4'h9, 1'b0);
      check("t4_abcd", 32'({a, b, c, d}), 32'h9999);
      idle(1);
      check("t4_no_err", 32'(err_cnt - e0), 32'd0);

      // 5. Early sync discards the partial frame
      e0 = err_cnt;
      send(4'h1, 1'b1);
      send(4'h2, 1'b0);
      send(4'hF, 1'b1);
      check("t5_err_pulse", 32'(sync_err), 32'd1);
      check("t5_locked", 32'(locked), 32'd1);
      check("t5_slot", 32'(slot), 32'd1);
      check("t5_hold", 32'({a, b, c, d}), 32'h9999);
      send(4'hE, 1'b0);
      check("t5_err_1cyc", 32'(sync_err), 32'd0);
      send(4'hD, 1'b0);
      sb.push_back({4'hF, 4'hE, 4'hD, 4'hB});
      send(4'hB, 1'b0);
      check("t5_abcd", 32'({a, b, c, d}), 32'hFEDB);
      idle(1);
      check("t5_err_cnt", 32'(err_cnt - e0), 32'd1);

      // 6. Missing sync, then reset in mid-frame
      e0 = err_cnt;
      send(4'h5, 1'b0);
      check("t6_err_pulse", 32'(sync_err), 32'd1);
      check("t6_unlocked", 32'(locked), 32'd0);
      check("t6_slot", 32'(slot), 32'd0);
      check("t6_hold", 32'({a, b, c, d}), 32'hFEDB);
      send(4'h4, 1'b1);
      send(4'h6, 1'b0);
      check("t6_relock", 32'(locked), 32'd1);
      check("t6_slot2", 32'(slot), 32'd2);
      reset_mid("t6_rst");
      send(4'h8, 1'b0);
      check("t6_hunt", 32'(locked), 32'd0);
      check("t6_err_cnt", 32'(err_cnt - e0), 32'd1);

      idle(2);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
